fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
Read-side controller for the team's show-ahead FIFO. On a start request it pops exactly N words from the FIFO's read port and drives them onto a registered valid/ready stream, marking the final word with last. It sits between a FIFO instance and a downstream consumer, such as a DMA packer or compute lane, that needs framed bursts.

Parameters:
WIDTH, 8, data width in bits; matches the attached FIFO.
MAX_BURST, 16, largest burst length supported; LW = $clog2(MAX_BURST)+1.
TIMEOUT, 64, stall cycles before abort; used only with the optional feature.

Ports:
clk  input  1  clock
rst_n  input  1  reset
start  input  1  burst request, sampled in IDLE only
burst_len  input  LW  words to transfer, sampled with start
busy  output  1  high from accepted start until done
done  output  1  single-cycle pulse when the burst completes
err  output  1  single-cycle pulse with done on timeout abort; always 0 without the feature
fifo_data  input  WIDTH  FIFO head word, valid while fifo_valid
fifo_valid  input  1  FIFO not empty
fifo_ren  output  1  pop strobe to the FIFO; the head advances next edge
out_data  output  WIDTH  stream data
out_valid  output  1  stream valid
out_ready  input  1  stream ready
out_last  output  1  final word of the burst, qualified by out_valid

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_last=0, out_data='0, busy=0, done=0, err=0, fifo_ren=0, remaining count=0.
- States:
  - IDLE: start=1 with burst_len>0 goes to STREAM. Load remaining=min(burst_len, MAX_BURST) (saturating). busy=1 from the next cycle.
  - IDLE: start=1 with burst_len=0 goes to DONE. No pop.
  - STREAM: pop and present words. When the last pop is issued (remaining 1->0), go to FLUSH.
  - FLUSH: wait for out_valid && out_ready on the last word, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in this cycle, return to IDLE.
- start outside IDLE is ignored. burst_len is not re-sampled mid-burst.
- Pop rule, combinational: fifo_ren = (state==STREAM) && remaining!=0 && fifo_valid && (!out_valid || out_ready).
  - Never pop when the FIFO is empty.
  - Never pop when the output register holds an unaccepted word.
- On a pop edge: out_data<=fifo_data, out_valid<=1, out_last<=(remaining==1), remaining<=remaining-1.
- On a handshake without a pop: out_valid<=0, out_last<=0.
- Latency: a FIFO word appears on out_data one cycle after its fifo_ren. Full throughput is one word per cycle while fifo_valid and out_ready stay high.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_valid and out_last hold stable. No pop occurs.
- FIFO empty mid-burst: out_valid may drop after its pending handshake. The burst resumes when fifo_valid returns, with no lost or duplicated words.
- Simultaneous handshake and pop in the same cycle: the output register is replaced with the new word, so no bubble is inserted.
- Reset mid-burst: all state clears immediately. Words already popped are discarded. No done pulse.
- remaining is LW bits wide and never underflows.

Optional Feature:
Macro: FIFO_BURST_READER_TIMEOUT_EN.
- Defined:
  - A stall counter increments each STREAM cycle with remaining!=0 && !fifo_valid.
  - It clears on any pop.
  - When it reaches TIMEOUT, go to FLUSH if out_valid=1, else to DONE. Remaining words are abandoned.
  - In the DONE cycle, err=1 alongside done=1.
  - out_last is not forced on abort.
- Not defined: no stall counter, err tied to 0, and the block waits indefinitely for FIFO data.

Test Plan:
1. FIFO preloaded with 0x10..0x13, out_ready=1, start with burst_len=4.
   - fifo_ren high for 4 consecutive cycles.
   - out_data 0x10,0x11,0x12,0x13 on consecutive cycles, out_last only with 0x13.
   - done pulses once; busy returns to 0.
2. Burst of 3 with out_ready toggling 1,0,0,1,...
   - out_data stable while stalled.
   - No fifo_ren during stalls.
   - Exactly 3 handshakes; the last has out_last=1.
3. burst_len=5 with only 2 words in the FIFO.
   - 2 words are delivered, then out_valid=0 and busy=1.
   - Push 3 more words: the burst completes with values in order and done pulses.
4. burst_len=0.
   - done pulses in the second cycle after start.
   - No fifo_ren, no out_valid.
5. burst_len=MAX_BURST+3, FIFO full of 32 words.
   - Exactly MAX_BURST words are popped.
   - Assert rst_n low mid-burst in a second run: all outputs are 0 immediately and the FIFO is untouched afterward.
6. With FIFO_BURST_READER_TIMEOUT_EN defined: burst_len=4, 1 word available, TIMEOUT=64.
   - 1 word is delivered.
   - done and err pulse together 64 stall cycles after the last pop.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a show-ahead FIFO: pops N words onto a registered valid/ready stream.
// Optional stall timeout/abort is enabled with `define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 64,
   localparam int LW       = $clog2(MAX_BURST) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LW-1:0]    burst_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_valid,
   output logic             fifo_ren,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } state_t;

   if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_check
      $error("fifo_burst_reader: MAX_BURST and TIMEOUT must be at least 1");
   end

   state_t        state_r;
   logic [LW-1:0] remaining_r;
   logic [LW-1:0] len_sat_s;
   logic          pop_s;
   logic          hs_s;
   logic          timeout_s;
   logic          abort_r;

   // Clamp oversized requests to the largest supported burst
   always_comb begin
      len_sat_s = burst_len;
      if (burst_len > LW'(MAX_BURST)) begin
         len_sat_s = LW'(MAX_BURST);
      end else begin
         len_sat_s = burst_len;
      end
   end

   // A pop may replace the output word in the same cycle it is accepted, so no bubble
   assign pop_s    = (state_r == STREAM) && (remaining_r != '0) && fifo_valid
                     && (!out_valid || out_ready);
   assign hs_s     = out_valid && out_ready;
   assign fifo_ren = pop_s;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);

   logic [SW-1:0] stall_r;
   logic          stall_s;

   assign stall_s   = (state_r == STREAM) && (remaining_r != '0) && !fifo_valid;
   assign timeout_s = stall_s && (stall_r == SW'(TIMEOUT - 1));

   // Stall counter and abort flag; the flag turns the eventual done into an error completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_r <= '0;
         abort_r <= 1'b0;
      end else begin
         if (pop_s || (state_r != STREAM)) begin
            stall_r <= '0;
         end else if (stall_s) begin
            stall_r <= stall_r + SW'(1);
         end
         if (state_r == DONE) begin
            abort_r <= 1'b0;
         end else if (timeout_s) begin
            abort_r <= 1'b1;
         end
      end
   end
`else
   assign timeout_s = 1'b0;
   assign abort_r   = 1'b0;
`endif

   // Burst sequencing and the registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         remaining_r <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         if (pop_s) begin
            out_data    <= fifo_data;
            out_valid   <= 1'b1;
            out_last    <= (remaining_r == LW'(1));
            remaining_r <= remaining_r - LW'(1);
         end else if (hs_s) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state_r)
            IDLE: begin
               if (start) begin
                  if (len_sat_s != '0) begin
                     state_r     <= STREAM;
                     remaining_r <= len_sat_s;
                     busy        <= 1'b1;
                  end else begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (pop_s && (remaining_r == LW'(1))) begin
                  state_r <= FLUSH;
               end else if (timeout_s) begin
                  // Abandon the unpopped words; a pending word must still drain
                  remaining_r <= '0;
                  if (out_valid && !out_ready) begin
                     state_r <= FLUSH;
                  end else begin
                     state_r <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (hs_s) begin
                  state_r <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  err     <= abort_r;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
